pipe_skid_stage: RTL and testbench

Consumer-side counterpart to the team's enable-loaded pipeline registers: a two-entry skid buffer that lets a downstream MIPS pipeline stage read 32-bit words with a valid/ready handshake. It replaces a raw `control`-style stall enable with back-pressure that has no combinational path. The upstream stage writes words in, and the downstream stage reads them out at up to one word per cycle. The ready signal seen by upstream is registered, so stall timing closes locally. The block sits between two pipeline stages (e.g. ID/EX); its `flush` input is driven by branch/hazard logic.

---
 rtl/pipe_skid_stage.sv | 155 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//   Two-entry skid buffer between two pipeline stages. Upstream pushes words
//   with a valid/ready handshake and downstream pops them at up to one word
//   per cycle. inReady comes straight from a flop, so there is no combinational
//   path from outReady or inValid back to upstream.
//
// Ports
//   CLK        rising-edge clock
//   RSTn       asynchronous active-low reset
//   dataIn     word offered by upstream
//   inValid    upstream has a word on dataIn
//   inReady    block can accept a word (registered)
//   dataOut    word presented downstream (main register)
//   outValid   dataOut holds a valid word
//   outReady   downstream accepts dataOut this cycle
//   flush      synchronous discard of all held words
//   occupancy  number of held words (0, 1 or 2)
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] dataOut,
  output logic             outValid,
  input  logic             outReady,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       occupancy_q, occupancy_d;

  logic             in_xfer_s;
  logic             out_xfer_s;

  // Handshakes are qualified by the registered flags, never by each other.
  assign in_xfer_s  = inValid && in_ready_q;
  assign out_xfer_s = out_valid_q && outReady;

  // State and storage registers; reset discards everything without a clock.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_EMPTY;
      main_q      <= {WIDTH{1'b0}};
      skid_q      <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
    end
  end

  // Next-state and data-path logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers keep stale contents; only the state is cleared.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_d = ST_BUSY;
            main_d  = dataIn;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (in_xfer_s && out_xfer_s) begin
            state_d = ST_BUSY;
            main_d  = dataIn;
          end else if (in_xfer_s) begin
            // Downstream stalled: the extra word lands in the skid register.
            state_d = ST_FULL;
            skid_d  = dataIn;
          end else if (out_xfer_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    occupancy_d = 2'd0;
    case (state_d)
      ST_EMPTY: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        occupancy_d = 2'd0;
      end
      ST_BUSY: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b1;
        occupancy_d = 2'd1;
      end
      ST_FULL: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        occupancy_d = 2'd2;
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        occupancy_d = 2'd0;
      end
    endcase
  end

  assign inReady   = in_ready_q;
  assign outValid  = out_valid_q;
  assign dataOut   = main_q;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
//   Directed vector table with hand-computed expectations, a mid-operation
//   asynchronous reset sequence, and a random valid/ready/flush phase checked
//   against a queue scoreboard.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

  localparam int W = 32;

  logic         CLK;
  logic         RSTn;
  logic [W-1:0] dataIn;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] dataOut;
  logic         outValid;
  logic         outReady;
  logic         flush;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  pipe_skid_stage #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .dataIn    (dataIn),
    .inValid   (inValid),
    .inReady   (inReady),
    .dataOut   (dataOut),
    .outValid  (outValid),
    .outReady  (outReady),
    .flush     (flush),
    .occupancy (occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic         fl;
    logic         e_ov;
    logic [W-1:0] e_do;
    logic         e_ir;
    logic [1:0]   e_occ;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [W-1:0] din, logic ordy, logic fl,
                              logic e_ov, logic [W-1:0] e_do, logic e_ir,
                              logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_do = e_do; v.e_ir = e_ir; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [W-1:0] dout,
                         input logic ir, input logic [1:0] occ);
    chk({tag, " outValid"},  {31'd0, outValid}, {31'd0, ov});
    chk({tag, " dataOut"},   dataOut, dout);
    chk({tag, " inReady"},   {31'd0, inReady}, {31'd0, ir});
    chk({tag, " occupancy"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next.
  task automatic step(input logic iv, input logic [W-1:0] din, input logic ordy,
                      input logic fl);
    inValid  = iv;
    dataIn   = din;
    outReady = ordy;
    flush    = fl;
    @(posedge CLK);
    #1;
  endtask

  // scoreboard for the random phase
  logic [W-1:0] sb [$];

  initial begin
    // filled table: iv, din, ordy, flush | outValid, dataOut, inReady, occupancy
    vecs[0]  = mk(1'b1, 32'h0000_00A5, 1'b1, 1'b0, 1'b1, 32'h0000_00A5, 1'b1, 2'd1);
    vecs[1]  = mk(1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 2'd1);
    vecs[2]  = mk(1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 2'd1);
    vecs[3]  = mk(1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 1'b1, 2'd1);
    vecs[4]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0003, 1'b1, 2'd0);
    vecs[5]  = mk(1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 1'b1, 2'd1);
    vecs[6]  = mk(1'b1, 32'h0000_0022, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 1'b0, 2'd2);
    vecs[7]  = mk(1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 1'b0, 2'd2);
    vecs[8]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0022, 1'b1, 2'd1);
    vecs[9]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0022, 1'b1, 2'd0);
    vecs[10] = mk(1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b1, 32'h0000_0033, 1'b1, 2'd1);
    vecs[11] = mk(1'b1, 32'h0000_0044, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 1'b1, 2'd1);
    vecs[12] = mk(1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 1'b0, 2'd2);
    vecs[13] = mk(1'b1, 32'h0000_0066, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 1'b1, 2'd0);
    vecs[14] = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 1'b1, 2'd0);
    vecs[15] = mk(1'b1, 32'h0000_0077, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 1'b1, 2'd0);
    vecs[16] = mk(1'b1, 32'h0000_0088, 1'b0, 1'b0, 1'b1, 32'h0000_0088, 1'b1, 2'd1);
    vecs[17] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0088, 1'b1, 2'd1);
    vecs[18] = mk(1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 32'h0000_0088, 1'b0, 2'd2);

    RSTn     = 1'b0;
    dataIn   = '0;
    inValid  = 1'b0;
    outReady = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", 1'b0, 32'h0, 1'b1, 2'd0);
    RSTn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_do, vecs[i].e_ir,
              vecs[i].e_occ);
    end

    // Mid-operation async reset while FULL: outputs clear with no clock edge.
    inValid  = 1'b0;
    outReady = 1'b0;
    #2;
    RSTn = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 1'b1, 2'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    chk_all("post_rst", 1'b0, 32'h0, 1'b1, 2'd0);

    // Random valid/ready/flush against a queue model.
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      logic         iv, ordy, fl, in_x, out_x;
      logic [W-1:0] din;
      logic [W-1:0] prev_do;
      logic         stalled;
      iv      = ($urandom_range(0, 99) < 60);
      ordy    = ($urandom_range(0, 99) < 55);
      fl      = ($urandom_range(0, 199) == 0);
      din     = $urandom;
      in_x    = iv && (sb.size() < 2);
      out_x   = ordy && (sb.size() > 0);
      stalled = (sb.size() > 0) && !ordy;
      prev_do = dataOut;
      step(iv, din, ordy, fl);
      if (fl) begin
        sb.delete();
      end else begin
        if (out_x) void'(sb.pop_front());
        if (in_x) sb.push_back(din);
      end
      chk("rnd outValid", {31'd0, outValid}, {31'd0, (sb.size() != 0)});
      chk("rnd occupancy", {30'd0, occupancy}, sb.size());
      chk("rnd inReady", {31'd0, inReady}, {31'd0, (sb.size() != 2)});
      if (sb.size() != 0) begin
        chk("rnd dataOut", dataOut, sb[0]);
        if (stalled && !fl) chk("rnd stable", dataOut, prev_do);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
